// File: rtl/icache_pkg.sv
// Shared widths, address field positions and FSM states for the instruction cache.
package icache_pkg;

    localparam int WORD_W         = 32;
    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int OFFSET_LSB     = 2;
    localparam int OFFSET_W       = 2;
    localparam int INDEX_LSB      = OFFSET_LSB + OFFSET_W;
    localparam int DEF_NUM_LINES  = 8;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } icache_state_t;

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_lsb(input int num_lines);
        return INDEX_LSB + index_w(num_lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Single write port, flush-all clear of the valid vector, combinational read.
module icache_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int IDX_W     = index_w(NUM_LINES),
    parameter int TAG_W     = 25
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush_all,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_index,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_block,
    input  logic [IDX_W-1:0]  i_rd_index,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_block
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    // A flush on the same edge as a fill wins: the new line must not survive.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush_all) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_block;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_block = r_data[i_rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: fill FSM and word select.
// state    | meaning
// IDLE     | lookup; hit returns word combinationally, miss starts a fill
// MEM_READ | block request held until memory drops busywait
// UPDATE   | captured block written into the line, back to IDLE
module instruction_cache
    import icache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] address,
    input  logic              flush,
    output logic [WORD_W-1:0] instruction,
    output logic              busywait,
    output logic              mem_read,
    output logic [ADDR_W-5:0] mem_address,
    input  logic [LINE_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    localparam int IDX_W   = index_w(NUM_LINES);
    localparam int TAG_LSB = tag_lsb(NUM_LINES);
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    icache_state_t     r_state;
    icache_state_t     w_next_state;
    logic              r_flush_pending;
    logic [LINE_W-1:0] r_fill_block;

    logic [IDX_W-1:0]    w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_line_valid;
    logic [TAG_W-1:0]    w_line_tag;
    logic [LINE_W-1:0]   w_line_block;
    logic                w_hit;
    logic                w_capture;
    logic                w_wr_en;
    logic                w_flush_all;
    logic                w_unused;

    assign w_index  = address[TAG_LSB-1:INDEX_LSB];
    assign w_tag    = address[ADDR_W-1:TAG_LSB];
    assign w_offset = address[INDEX_LSB-1:OFFSET_LSB];
    assign w_unused = ^address[OFFSET_LSB-1:0];

    assign w_hit   = w_line_valid && (w_line_tag == w_tag);
    assign w_wr_en = (r_state == UPDATE) && !RESET;

    // A flush seen during a fill is deferred so it also clears the line being written.
    assign w_flush_all = ((r_state == IDLE) && flush) ||
                         ((r_state == UPDATE) && (r_flush_pending || flush));

    icache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .i_clk       (CLK),
        .i_reset     (RESET),
        .i_flush_all (w_flush_all),
        .i_wr_en     (w_wr_en),
        .i_wr_index  (w_index),
        .i_wr_tag    (w_tag),
        .i_wr_block  (r_fill_block),
        .i_rd_index  (w_index),
        .o_rd_valid  (w_line_valid),
        .o_rd_tag    (w_line_tag),
        .o_rd_block  (w_line_block)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state         <= IDLE;
            r_flush_pending <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == UPDATE) begin
                r_flush_pending <= 1'b0;
            end else if (flush && (r_state != IDLE)) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_capture) begin
            r_fill_block <= mem_readdata;
        end
    end

    // A flush alongside a request stalls one cycle; the lookup is redone against the cleared array.
    always_comb begin
        w_next_state = r_state;
        busywait     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (read_en) begin
                    busywait = flush || !w_hit;
                    if (!flush && !w_hit) begin
                        w_next_state = MEM_READ;
                    end
                end
            end
            MEM_READ: begin
                busywait = 1'b1;
                if (!mem_busywait) begin
                    w_capture    = 1'b1;
                    w_next_state = UPDATE;
                end
            end
            UPDATE: begin
                busywait     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign mem_read    = (r_state == MEM_READ);
    assign mem_address = address[ADDR_W-1:INDEX_LSB];
    assign instruction = w_line_block[{w_offset, 5'b0} +: WORD_W];

endmodule
